// File: rtl/rvfi_commit_serializer.sv
// RVFI commit serializer: compacts the multi-port retirement bundle into a
// program-order FIFO and emits one entry per cycle. Stats behind RVFI_SER_STATS_EN.
package rvfi_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [1:0]  mode;
    logic [4:0]  rd_addr;
    logic [63:0] rd_wdata;
    logic [63:0] pc_rdata;
    logic [63:0] pc_wdata;
  } rvfi_instr_t;
endpackage

module rvfi_commit_serializer
  import rvfi_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 16
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  rvfi_instr_t [NR_COMMIT_PORTS-1:0]       rvfi_i,
  output rvfi_instr_t                             rvfi_o,
  output logic                                    valid_o,
  input  logic                                    ready_i,
  output logic                                    almost_full_o,
  output logic                                    overflow_o,
  output logic [$clog2(DEPTH):0]                  count_o,
  output logic [$clog2(DEPTH):0]                  hwm_o,
  output logic [31:0]                             drop_cnt_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NR = NR_COMMIT_PORTS;
  typedef logic [AW:0] ptr_t;

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 2 * NR)) begin : g_param_err
    $error("rvfi_commit_serializer: DEPTH must be a power of 2 and >= 2*NR_COMMIT_PORTS");
  end

  ptr_t          wr_q, wr_d, rd_q, rd_d;
  ptr_t          cnt, free, n_adm, n_st, n_drop;
  logic          empty, pop, overflow_q, overflow_d;
  logic [NR-1:0] store;
  logic [AW-1:0] widx [NR];
  rvfi_instr_t   mem_q [DEPTH];

  assign cnt   = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  // Free space uses pre-pop occupancy so ready_i never reaches write enables.
  assign free  = ptr_t'(DEPTH) - cnt;
  assign pop   = !empty && ready_i;

  always_comb begin
    n_adm = '0;
    store = '0;
    for (int i = 0; i < NR; i++) begin
      widx[i] = wr_q[AW-1:0] + n_adm[AW-1:0];
      if (rvfi_i[i].valid || rvfi_i[i].trap) begin
        store[i] = (n_adm < free);
        n_adm    = n_adm + ptr_t'(1);
      end
    end
    n_st       = (n_adm > free) ? free : n_adm;
    n_drop     = n_adm - n_st;
    wr_d       = wr_q + n_st;
    rd_d       = rd_q + {{AW{1'b0}}, pop};
    overflow_d = overflow_q || (n_drop != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is intentionally unreset; pointers alone define validity.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NR; i++)
      if (store[i]) mem_q[widx[i]] <= rvfi_i[i];
  end

  assign valid_o       = !empty;
  assign rvfi_o        = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign count_o       = cnt;
  assign almost_full_o = (cnt >= ptr_t'(DEPTH - NR));
  assign overflow_o    = overflow_q;

`ifdef RVFI_SER_STATS_EN
  ptr_t        hwm_q, hwm_d, cnt_d;
  logic [31:0] drop_q, drop_d;
  logic [32:0] dsum;

  always_comb begin
    cnt_d  = wr_d - rd_d;
    hwm_d  = (cnt_d > hwm_q) ? cnt_d : hwm_q;
    dsum   = {1'b0, drop_q} + {{(32 - AW){1'b0}}, n_drop};
    drop_d = dsum[32] ? 32'hFFFF_FFFF : dsum[31:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hwm_q  <= '0;
      drop_q <= '0;
    end else begin
      hwm_q  <= hwm_d;
      drop_q <= drop_d;
    end
  end

  assign hwm_o      = hwm_q;
  assign drop_cnt_o = drop_q;
`else
  assign hwm_o      = '0;
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Bench for rvfi_commit_serializer: random commit bundles against a queue model.
module tb_rvfi_commit_serializer;
  import rvfi_pkg::*;

  localparam int NR = 2;
  localparam int DP = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  rvfi_instr_t [NR-1:0]   rvfi_in;
  rvfi_instr_t            rvfi_out;
  logic                   valid, ready, af, ovf;
  logic [3:0]             cnt, hwm;
  logic [31:0]            dropc;

  int          vectors = 0;
  int          miscompares = 0;
  rvfi_instr_t mq[$];
  bit          m_ovf;
  int          m_hwm;
  longint      m_drop;

  rvfi_commit_serializer #(.NR_COMMIT_PORTS(NR), .DEPTH(DP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rvfi_i(rvfi_in), .rvfi_o(rvfi_out),
    .valid_o(valid), .ready_i(ready), .almost_full_o(af), .overflow_o(ovf),
    .count_o(cnt), .hwm_o(hwm), .drop_cnt_o(dropc)
  );

  always #5 clk = ~clk;

  function automatic rvfi_instr_t rnd(bit v, bit t, logic [63:0] pc);
    rvfi_instr_t r;
    r          = '0;
    r.valid    = v;
    r.trap     = t;
    r.order    = {$urandom, $urandom};
    r.insn     = $urandom;
    r.mode     = 2'($urandom);
    r.rd_addr  = 5'($urandom);
    r.rd_wdata = {$urandom, $urandom};
    r.pc_rdata = pc;
    r.pc_wdata = pc + 64'd4;
    return r;
  endfunction

  function automatic rvfi_instr_t exp_head();
    return (mq.size() != 0) ? mq[0] : '0;
  endfunction

  function automatic int exp_hwm();
`ifdef RVFI_SER_STATS_EN
    return m_hwm;
`else
    return 0;
`endif
  endfunction

  function automatic longint exp_drop();
`ifdef RVFI_SER_STATS_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  // Drive one cycle of inputs and advance the model; no checking here.
  task automatic step(input rvfi_instr_t [NR-1:0] b, input bit rdy);
    int fr;
    fr      = DP - mq.size();
    rvfi_in = b;
    ready   = rdy;
    if (rdy && mq.size() != 0) void'(mq.pop_front());
    for (int i = 0; i < NR; i++)
      if (b[i].valid || b[i].trap) begin
        if (fr > 0) begin mq.push_back(b[i]); fr--; end
        else begin m_ovf = 1'b1; m_drop++; end
      end
    if (mq.size() > m_hwm) m_hwm = mq.size();
    @(posedge clk);
    @(negedge clk);
    rvfi_in = '0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    rvfi_in = '0;
    ready   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_ovf = 0; m_hwm = 0; m_drop = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rvfi_in = '0; ready = 1'b0;
    #1;
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset valid got %b want 0", valid); end
    vectors++; if (rvfi_out !== '0) begin miscompares++; $display("FAIL reset rvfi_o got %h want 0", rvfi_out); end
    vectors++; if (cnt !== 4'd0) begin miscompares++; $display("FAIL reset count got %0d want 0", cnt); end
    vectors++; if (af !== 1'b0 || ovf !== 1'b0) begin miscompares++; $display("FAIL reset flags got af=%b ovf=%b want 0/0", af, ovf); end
    vectors++; if (hwm !== 4'd0 || dropc !== 32'd0) begin miscompares++; $display("FAIL reset stats got hwm=%0d drop=%0d want 0/0", hwm, dropc); end
    do_reset();
  endtask

  task automatic test_ordering();
    rvfi_instr_t [NR-1:0] b;
    do_reset();
    b[0] = rnd(1, 0, 64'h1000);
    b[1] = rnd(1, 0, 64'h1004);
    step(b, 1);
    vectors++; if (valid !== 1'b1 || rvfi_out.pc_rdata !== 64'h1000) begin miscompares++; $display("FAIL order first got v=%b pc=%h want 1/1000", valid, rvfi_out.pc_rdata); end
    vectors++; if (rvfi_out !== exp_head()) begin miscompares++; $display("FAIL order entry0 got %h want %h", rvfi_out, exp_head()); end
    step('0, 1);
    vectors++; if (rvfi_out.pc_rdata !== 64'h1004 || rvfi_out !== exp_head()) begin miscompares++; $display("FAIL order second got pc=%h want 1004", rvfi_out.pc_rdata); end
    step('0, 1);
    vectors++; if (valid !== 1'b0 || rvfi_out !== '0) begin miscompares++; $display("FAIL order empty got v=%b out=%h want 0/0", valid, rvfi_out); end
  endtask

  task automatic test_compaction();
    rvfi_instr_t [NR-1:0] b;
    do_reset();
    b[0] = rnd(0, 0, 64'hDEAD);
    b[1] = rnd(0, 1, 64'h2000);
    step(b, 0);
    b    = '0;
    b[0] = rnd(1, 0, 64'h2004);
    step(b, 0);
    vectors++; if (cnt !== 4'd2) begin miscompares++; $display("FAIL compact count got %0d want 2", cnt); end
    vectors++; if (rvfi_out.pc_rdata !== 64'h2000 || rvfi_out !== exp_head()) begin miscompares++; $display("FAIL compact head got pc=%h want 2000", rvfi_out.pc_rdata); end
    step('0, 1);
    vectors++; if (rvfi_out.pc_rdata !== 64'h2004 || cnt !== 4'd1) begin miscompares++; $display("FAIL compact second got pc=%h cnt=%0d want 2004/1", rvfi_out.pc_rdata, cnt); end
    step('0, 1);
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL compact drain got v=%b want 0", valid); end
  endtask

  task automatic test_overflow();
    rvfi_instr_t [NR-1:0] b;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      b[0] = rnd(1, 0, 64'h3000 + 64'(8 * c));
      b[1] = rnd(1, 0, 64'h3004 + 64'(8 * c));
      step(b, 0);
      vectors++; if (cnt !== 4'(mq.size()) || af !== (mq.size() >= DP - NR) || ovf !== m_ovf) begin
        miscompares++; $display("FAIL ovf fill%0d got cnt=%0d af=%b ovf=%b want %0d/%b/%b", c, cnt, af, ovf, mq.size(), mq.size() >= DP - NR, m_ovf);
      end
    end
    vectors++; if (cnt !== 4'd8 || ovf !== 1'b1) begin miscompares++; $display("FAIL ovf full got cnt=%0d ovf=%b want 8/1", cnt, ovf); end
    vectors++; if (dropc !== 32'(exp_drop()) || hwm !== 4'(exp_hwm())) begin miscompares++; $display("FAIL ovf stats got drop=%0d hwm=%0d want %0d/%0d", dropc, hwm, exp_drop(), exp_hwm()); end
    for (int k = 0; k < 8; k++) begin
      vectors++; if (rvfi_out.pc_rdata !== 64'h3000 + 64'(4 * k) || rvfi_out !== exp_head()) begin
        miscompares++; $display("FAIL ovf drain%0d got pc=%h want %h", k, rvfi_out.pc_rdata, 64'h3000 + 64'(4 * k));
      end
      step('0, 1);
    end
    vectors++; if (valid !== 1'b0 || ovf !== 1'b1) begin miscompares++; $display("FAIL ovf after got v=%b ovf=%b want 0/1", valid, ovf); end
  endtask

  task automatic test_wrap();
    rvfi_instr_t [NR-1:0] b;
    logic [63:0] pc;
    do_reset();
    pc = 64'h4000;
    for (int c = 0; c < 20; c++) begin
      b[0] = rnd(1, 0, pc);
      b[1] = rnd($urandom_range(0, 1), 1, pc + 64'd4);
      pc   = pc + 64'd8;
      step(b, 1);
      vectors++; if (rvfi_out !== exp_head() || cnt !== 4'(mq.size()) || cnt > 4'd8 || ovf !== m_ovf) begin
        miscompares++; $display("FAIL wrap cyc%0d got pc=%h cnt=%0d ovf=%b want pc=%h cnt=%0d ovf=%b", c, rvfi_out.pc_rdata, cnt, ovf, exp_head().pc_rdata, mq.size(), m_ovf);
      end
    end
    for (int k = 0; k < 12 && mq.size() != 0; k++) begin
      step('0, 1);
      vectors++; if (rvfi_out !== exp_head() || valid !== (mq.size() != 0)) begin
        miscompares++; $display("FAIL wrap drain%0d got pc=%h want %h", k, rvfi_out.pc_rdata, exp_head().pc_rdata);
      end
    end
    vectors++; if (dropc !== 32'(exp_drop()) || hwm !== 4'(exp_hwm())) begin miscompares++; $display("FAIL wrap stats got drop=%0d hwm=%0d want %0d/%0d", dropc, hwm, exp_drop(), exp_hwm()); end
  endtask

  task automatic test_backpressure();
    rvfi_instr_t [NR-1:0] b;
    rvfi_instr_t prev;
    logic pv;
    bit rdy;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      b[0] = rnd($urandom_range(0, 1), 0, 64'h6000 + 64'(8 * c));
      b[1] = rnd(0, $urandom_range(0, 3) == 0, 64'h6004 + 64'(8 * c));
      rdy  = (c % 2) == 1;
      prev = rvfi_out;
      pv   = valid;
      step(b, rdy);
      if (!rdy && pv) begin
        vectors++; if (rvfi_out !== prev) begin miscompares++; $display("FAIL bp stable cyc%0d got pc=%h want %h", c, rvfi_out.pc_rdata, prev.pc_rdata); end
      end
      vectors++; if (rvfi_out !== exp_head() || cnt !== 4'(mq.size())) begin
        miscompares++; $display("FAIL bp head cyc%0d got pc=%h cnt=%0d want pc=%h cnt=%0d", c, rvfi_out.pc_rdata, cnt, exp_head().pc_rdata, mq.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    rvfi_instr_t [NR-1:0] b;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      b[0] = rnd(1, 0, 64'h7000 + 64'(8 * c));
      b[1] = rnd(1, 0, 64'h7004 + 64'(8 * c));
      step(b, 0);
    end
    repeat (3) step('0, 1);
    vectors++; if (cnt !== 4'd5 || ovf !== 1'b1 || rvfi_out !== exp_head()) begin miscompares++; $display("FAIL rstmid pre got cnt=%0d ovf=%b want 5/1", cnt, ovf); end
    rst_n = 1'b0;
    #1;
    vectors++; if (valid !== 1'b0 || cnt !== 4'd0 || ovf !== 1'b0 || rvfi_out !== '0) begin
      miscompares++; $display("FAIL rstmid async got v=%b cnt=%0d ovf=%b want 0/0/0", valid, cnt, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); m_ovf = 0; m_hwm = 0; m_drop = 0;
    @(negedge clk);
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL rstmid release got v=%b want 0", valid); end
    b    = '0;
    b[0] = rnd(1, 0, 64'h5000);
    step(b, 0);
    vectors++; if (rvfi_out !== b[0] || cnt !== 4'd1) begin miscompares++; $display("FAIL rstmid first got pc=%h cnt=%0d want 5000/1", rvfi_out.pc_rdata, cnt); end
  endtask

  initial begin
    rst_n   = 1'b0;
    rvfi_in = '0;
    ready   = 1'b0;
    @(negedge clk);
    test_reset();
    test_ordering();
    test_compaction();
    test_overflow();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rvfi_commit_serializer.md
Name: rvfi_commit_serializer

Overview:
Sits directly upstream of the RVFI trace consumer. Takes the NR_COMMIT_PORTS-wide per-cycle retirement bundle, buffers it in a program-order FIFO and emits one retired instruction or trap per cycle over a valid/ready port. Downstream tracers, checkers and co-simulation hooks then see a strictly ordered single stream and need no multi-port loop. Overflow is flagged, never silent, because commit cannot be back-pressured.

Parameters:
NR_COMMIT_PORTS, 2, number of parallel commit ports on rvfi_i.
DEPTH, 16, FIFO entries. Must be a power of 2 and >= 2*NR_COMMIT_PORTS; elaboration-time $error otherwise.

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, asynchronous, active-low
rvfi_i  input  rvfi_pkg::rvfi_instr_t[NR_COMMIT_PORTS-1:0]  commit bundle; port 0 is oldest
rvfi_o  output  rvfi_pkg::rvfi_instr_t  head entry; '0 when empty
valid_o  output  1  rvfi_o holds a valid entry
ready_i  input  1  consumer accepts rvfi_o this cycle
almost_full_o  output  1  count >= DEPTH-NR_COMMIT_PORTS
overflow_o  output  1  sticky; at least one entry dropped since reset
count_o  output  $clog2(DEPTH)+1  current occupancy
hwm_o  output  $clog2(DEPTH)+1  occupancy high-water mark (feature)
drop_cnt_o  output  32  dropped-entry counter (feature)

Behaviour:
- Admission: port i is admitted when rvfi_i[i].valid | rvfi_i[i].trap. Non-admitted ports are ignored and leave no gaps.
- Compaction: admitted entries are written to consecutive slots starting at wr_ptr, in ascending port order. Program order is preserved across ports and cycles.
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH)+1 bits, including a wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
  - count = wr_ptr - rd_ptr, modulo width.
- Output is first-word-fall-through:
  - valid_o = !empty.
  - rvfi_o = mem[rd_ptr index] when valid_o, else '0.
  - Pop occurs when valid_o & ready_i.
- Latency: an entry written at clock edge k appears on rvfi_o after edge k, i.e. next cycle, if it is at the head. There is no bypass from rvfi_i to rvfi_o.
- While valid_o=1 and ready_i=0, rvfi_o is stable.
- Free space: free = DEPTH - count, using count before this cycle's pop. This keeps the path from ready_i to write-enable non-combinational. A pop in the same cycle frees space only for the next cycle.
- Overflow, when admitted n > free:
  - The lowest `free` admitted ports are stored.
  - The remainder are dropped.
  - overflow_o is set and held until reset.
- Simultaneous push and pop: both pointers update in the same edge. count changes by pushed - popped.
- Wrap-around: multi-entry writes that straddle the last index wrap to index 0 in the same cycle.
- Reset values, asynchronous:
  - rd_ptr, wr_ptr = 0.
  - valid_o = 0, rvfi_o = '0, count_o = 0.
  - almost_full_o = 0, overflow_o = 0.
  - hwm_o = 0, drop_cnt_o = 0.
  - Storage array is not reset.
- Reset mid-operation: all buffered entries are discarded. No partial entry is presented after reset release.
- No state machine beyond pointers and flags. All outputs are registered or derived from registers only (ready_i affects nothing combinationally except the next state).

Optional Feature:
Macro RVFI_SER_STATS_EN.
- Defined:
  - hwm_o holds the maximum count_o since reset, updated when post-update count exceeds it.
  - drop_cnt_o increments by the number of entries dropped each cycle, saturating at 32'hFFFF_FFFF.
- Undefined: hwm_o and drop_cnt_o are tied to 0 and no counter logic is synthesised. The port list is unchanged either way.

Test Plan:
- Run all tests with NR_COMMIT_PORTS=2, DEPTH=8.
- Ordering: one cycle with port0 pc=0x1000 valid and port1 pc=0x1004 valid; ready_i=1 -> rvfi_o.pc_rdata 0x1000 next cycle, then 0x1004; valid_o then drops.
- Compaction: port0 invalid, port1 trap pc=0x2000; next cycle port0 valid pc=0x2004 -> stream 0x2000 then 0x2004 in consecutive slots; count_o peaks at 2 if ready_i=0.
- Overflow: ready_i=0; push 2 per cycle for 5 cycles (10 entries) -> count_o=8, almost_full_o=1 at count 6, overflow_o=1. With stats enabled, drop_cnt_o=2 and hwm_o=8. Draining yields the first 8 PCs in order.
- Wrap and simultaneous push/pop: ready_i=1, push 2 per cycle for 20 cycles -> output sequence is gap-free and in order; count_o never exceeds 8; overflow_o is set when free < 2 (expected once count saturates), and checked against the scoreboard.
- Backpressure stability: ready_i toggles 0/1 each cycle -> rvfi_o is unchanged during every ready_i=0 cycle with valid_o=1.
- Reset mid-operation: assert rst_ni=0 with count_o=5 -> valid_o=0, count_o=0, overflow_o=0 immediately. The first entry pushed after release is the first output.
